match_scheduler: RTL and testbench
==================================

# match_scheduler

Round-robin scheduler that shares the single matching core between `NUM_REQ` order-entry requesters during a trading session. It issues one grant at a time, starts the core, and waits for the result. Each successful match becomes a one-cycle `enable_count` pulse to the trade counter. Once the counter raises `halt_signal`, the scheduler stops issuing grants.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: number of WAIT cycles without `core_done` before the transaction is aborted, ≥2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high; clears all state on the next rising edge.
- `start` input 1: session start pulse.
- `stop` input 1: session stop pulse.
- `req` input NUM_REQ: per-requester request level.
- `grant` output NUM_REQ: one-hot grant, or zero.
- `core_start` output 1: one-cycle start pulse to the matching core.
- `core_done` input 1: core finished the current transaction.
- `core_match` input 1: result qualifier, sampled only with `core_done`; 1 = trade executed.
- `halt_signal` input 1: trade-limit halt from the trade counter.
- `enable_count` output 1: one-cycle trade pulse to the trade counter.
- `busy` output 1: high in ARB, WAIT and SETTLE.
- `state` output 3: IDLE=0, ARB=1, WAIT=2, SETTLE=3, HALTED=4.
- `last_id` output clog2(NUM_REQ): index of the last requester served.
- `timeout_err` output 1: sticky abort flag; cleared only by reset.

## Operation
- All outputs are registered.
- Reset values:
  - `grant`=0, `core_start`=0, `enable_count`=0, `busy`=0.
  - `state`=IDLE, `timeout_err`=0.
  - `last_id`=NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - `grant`=0.
  - `start`=1 and `stop`=0 → ARB.
  - `start` and `stop` together: stop wins, remain in IDLE.
- ARB:
  - `stop` → IDLE.
  - Else `halt_signal` → HALTED; halt has priority over any pending request.
  - Else, if any `req` bit is set: search from `last_id+1` upward with wrap-around and take the first set bit.
  - On a grant: `grant`=onehot(index), `core_start`=1, timer cleared, → WAIT.
  - With no request, remain in ARB.
- WAIT:
  - `grant` is held constant. `req` dropping is ignored; the transaction completes.
  - `core_start` is high only in the first WAIT cycle.
  - On `core_done`:
    - `grant`←0 and `enable_count`←`core_match`.
    - `last_id`←granted index.
    - → SETTLE.
  - Timeout: with no `core_done` and timer = TIMEOUT-1:
    - `grant`←0 and `timeout_err`←1.
    - `last_id`←granted index, so the stalled requester loses priority.
    - `enable_count` stays 0.
    - → SETTLE.
  - `core_done` and timeout in the same cycle: done wins.
  - `stop` during WAIT is latched into `stop_pending`. It does not abort the transaction.
- SETTLE:
  - Exactly one cycle. This gives the counter time to register the pulse, so `halt_signal` is valid at the next ARB decision.
  - `stop_pending` or `stop` → IDLE, clearing `stop_pending`.
  - Else → ARB.
  - `enable_count` returns to 0.
- HALTED:
  - `grant`=0 and `busy`=0.
  - `start` and `stop` are ignored. Exit only via `reset`.
- `core_done` outside WAIT is ignored.
- Timer width: clog2(TIMEOUT+1).

## Timing
- A grant takes 1 edge: `req` sampled in ARB at edge k gives `grant` and `core_start` high from k.
- `core_done` sampled at edge m gives `grant` low, and `enable_count` high for one cycle, from edge m.
- The next grant comes no earlier than edge m+2, after SETTLE.
- Minimum period per transaction is 3 cycles, with `core_done` returned in the first WAIT cycle.
- `reset` in any state: all outputs take their reset values at the same edge. Any in-flight transaction is dropped with no `enable_count`.

## Test plan
1. Reset, then `start` with `req`=0001 and `core_done`/`core_match`=1 on the 3rd WAIT cycle.
   - Required: `grant`=0001 and `core_start` for 1 cycle; `enable_count` for 1 cycle on the edge that samples done; `last_id`=0.
2. `req`=1111 held, every transaction matching.
   - Required: grants in order 0001, 0010, 0100, 1000, 0001; exactly one grant at a time; 4 `enable_count` pulses.
3. Trade counter model connected at count 98, `req`=0001, matches continuing.
   - Required: counter reaches 99, the next pulse raises halt, and the scheduler goes ARB→HALTED with no further grant.
   - Required: `stop`/`start` have no effect; `reset` returns the scheduler to IDLE.
4. `req`=0100 and 0001, `core_done` never asserted.
   - Required: `grant`=0100 drops after 16 WAIT cycles; `timeout_err`=1 and stays 1; next grant is 0001; a late `core_done` is ignored.
5. `stop` pulsed mid-WAIT, then `core_done` with `core_match`=1.
   - Required: the grant is held until done; `enable_count` still pulses; then SETTLE→IDLE.
   - Also: `start`+`stop` in the same IDLE cycle keeps the scheduler in IDLE.
6. `core_done` with `core_match`=0.
   - Required: no `enable_count` pulse; `last_id` still advances.
   - Also: `reset` asserted mid-WAIT clears `grant` at the same edge.

Source files
------------

// File: rtl/match_scheduler_if.sv
`default_nettype none
// ============================================================================
// match_scheduler_if : request/grant/core/counter bundle around match_scheduler
// Revision 1.0 - initial release
// ============================================================================
interface match_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               start;
  logic               stop;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               core_start;
  logic               core_done;
  logic               core_match;
  logic               halt_signal;
  logic               enable_count;
  logic               busy;
  logic [2:0]         state;
  logic [IDW-1:0]     last_id;
  logic               timeout_err;

  // Environment side: requesters, matching core and trade counter.
  modport master (
    output start, stop, req, core_done, core_match, halt_signal,
    input  grant, core_start, enable_count, busy, state, last_id, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  start, stop, req, core_done, core_match, halt_signal,
    output grant, core_start, enable_count, busy, state, last_id, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/match_scheduler.sv
`default_nettype none
// ============================================================================
// match_scheduler : round-robin sharing of one matching core between requesters
// Revision 1.0 - initial release
// ============================================================================
module match_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  match_scheduler_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               core_start_q;
  logic               enable_count_q;
  logic               busy_q;
  logic               timeout_err_q;
  logic               stop_pending_q;
  logic [IDW-1:0]     last_id_q;
  logic [IDW-1:0]     gidx_q;
  logic [TW-1:0]      timer_q;

  logic [IDW-1:0]     w_pick;
  logic [IDW-1:0]     w_idx;
  logic               w_any;

  // Walk offsets from farthest to nearest so the nearest set bit after
  // last_id is the one that sticks.
  always_comb begin
    w_pick = last_id_q;
    w_idx  = last_id_q;
    w_any  = |bus.req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_idx = IDW'((int'(last_id_q) + i) % NUM_REQ);
      if (bus.req[w_idx]) begin
        w_pick = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      core_start_q   <= 1'b0;
      enable_count_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      stop_pending_q <= 1'b0;
      last_id_q      <= LAST_RST;
      gidx_q         <= '0;
      timer_q        <= '0;
    end else begin
      core_start_q   <= 1'b0;
      enable_count_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          grant_q <= '0;
          if (bus.start && !bus.stop) begin
            state_q <= S_ARB;
            busy_q  <= 1'b1;
          end
        end
        S_ARB: begin
          if (bus.stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.halt_signal) begin
            state_q <= S_HALTED;
            busy_q  <= 1'b0;
          end else if (w_any) begin
            grant_q      <= NUM_REQ'(1) << w_pick;
            gidx_q       <= w_pick;
            core_start_q <= 1'b1;
            timer_q      <= '0;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (bus.stop) begin
            stop_pending_q <= 1'b1;
          end
          // A done arriving on the last allowed cycle still counts as a result.
          if (bus.core_done) begin
            grant_q        <= '0;
            enable_count_q <= bus.core_match;
            last_id_q      <= gidx_q;
            state_q        <= S_SETTLE;
          end else if (timer_q == TMAX) begin
            grant_q       <= '0;
            timeout_err_q <= 1'b1;
            last_id_q     <= gidx_q;
            state_q       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          stop_pending_q <= 1'b0;
          if (stop_pending_q || bus.stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_ARB;
          end
        end
        S_HALTED: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.core_start   = core_start_q;
  assign bus.enable_count = enable_count_q;
  assign bus.busy         = busy_q;
  assign bus.state        = state_q;
  assign bus.last_id      = last_id_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_match_scheduler.sv
`default_nettype none
// ============================================================================
// tb_match_scheduler : directed self-checking bench for match_scheduler
// Revision 1.0 - initial release
// ============================================================================
module tb_match_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  // Trade counter model: loads 98, counts pulses, halts at 100.
  int   cnt;
  logic cnt_load;
  logic cnt_on;

  logic [3:0] exp_g [5];

  match_scheduler_if #(.NUM_REQ(N)) bus ();

  match_scheduler #(.NUM_REQ(N), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_load) cnt <= 98;
    else if (bus.enable_count) cnt <= cnt + 1;
  end

  assign bus.halt_signal = cnt_on && (cnt >= 100);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic start_session();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.req = '0;
    bus.core_done = 1'b0; bus.core_match = 1'b0;
    cnt_load = 1'b1; cnt_on = 1'b0;
    step(); step();
    cnt_load = 1'b0;

    // Reset state
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_core_start", 32'(bus.core_start), 0);
    chk("rst_enable", 32'(bus.enable_count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_last_id", 32'(bus.last_id), 3);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    reset = 1'b0;

    // 1: single requester, done on 3rd WAIT cycle
    bus.req = 4'b0001;
    start_session();
    chk("t1_state_arb", 32'(bus.state), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    step();
    chk("t1_grant", 32'(bus.grant), 4'b0001);
    chk("t1_core_start", 32'(bus.core_start), 1);
    chk("t1_state_wait", 32'(bus.state), 2);
    step();
    chk("t1_core_start_off", 32'(bus.core_start), 0);
    chk("t1_grant_held", 32'(bus.grant), 4'b0001);
    step();
    bus.core_done = 1'b1; bus.core_match = 1'b1; bus.req = '0;
    step();
    bus.core_done = 1'b0; bus.core_match = 1'b0;
    chk("t1_grant_drop", 32'(bus.grant), 0);
    chk("t1_enable", 32'(bus.enable_count), 1);
    chk("t1_last_id", 32'(bus.last_id), 0);
    chk("t1_state_settle", 32'(bus.state), 3);
    step();
    chk("t1_enable_off", 32'(bus.enable_count), 0);
    chk("t1_state_arb2", 32'(bus.state), 1);

    // 2: all requesting, rotation from requester 0
    do_reset();
    start_session();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_grant", 32'(bus.grant), 32'(exp_g[i]));
      chk("t2_core_start", 32'(bus.core_start), 1);
      bus.core_done = 1'b1; bus.core_match = 1'b1;
      step();
      bus.core_done = 1'b0; bus.core_match = 1'b0;
      chk("t2_enable", 32'(bus.enable_count), 1);
      chk("t2_grant_drop", 32'(bus.grant), 0);
      step();
      chk("t2_state_arb", 32'(bus.state), 1);
    end
    bus.req = '0;

    // 3: trade limit halt
    do_reset();
    cnt_load = 1'b1; step(); cnt_load = 1'b0; cnt_on = 1'b1;
    bus.req = 4'b0001;
    start_session();
    step();
    chk("t3_grant_a", 32'(bus.grant), 4'b0001);
    bus.core_done = 1'b1; bus.core_match = 1'b1;
    step();
    bus.core_done = 1'b0; bus.core_match = 1'b0;
    step();
    chk("t3_cnt99", 32'(cnt), 99);
    chk("t3_no_halt", 32'(bus.halt_signal), 0);
    step();
    chk("t3_grant_b", 32'(bus.grant), 4'b0001);
    bus.core_done = 1'b1; bus.core_match = 1'b1;
    step();
    bus.core_done = 1'b0; bus.core_match = 1'b0;
    step();
    chk("t3_halt", 32'(bus.halt_signal), 1);
    chk("t3_arb", 32'(bus.state), 1);
    step();
    chk("t3_halted", 32'(bus.state), 4);
    chk("t3_no_grant", 32'(bus.grant), 0);
    chk("t3_busy", 32'(bus.busy), 0);
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
    bus.start = 1'b0;
    chk("t3_still_halted", 32'(bus.state), 4);
    chk("t3_still_no_grant", 32'(bus.grant), 0);
    do_reset();
    cnt_on = 1'b0;
    bus.req = '0;
    chk("t3_reset_idle", 32'(bus.state), 0);

    // 4: timeout on requester 2, then requester 0
    bus.req = 4'b0100;
    start_session();
    step();
    chk("t4_grant", 32'(bus.grant), 4'b0100);
    bus.req = 4'b0101;
    for (int i = 0; i < 15; i++) step();
    chk("t4_grant_held", 32'(bus.grant), 4'b0100);
    chk("t4_no_err_yet", 32'(bus.timeout_err), 0);
    step();
    chk("t4_grant_drop", 32'(bus.grant), 0);
    chk("t4_err", 32'(bus.timeout_err), 1);
    chk("t4_no_enable", 32'(bus.enable_count), 0);
    chk("t4_last_id", 32'(bus.last_id), 2);
    chk("t4_settle", 32'(bus.state), 3);
    bus.core_done = 1'b1; bus.core_match = 1'b1;
    step();
    bus.core_done = 1'b0; bus.core_match = 1'b0;
    chk("t4_late_done_ignored", 32'(bus.enable_count), 0);
    chk("t4_arb", 32'(bus.state), 1);
    step();
    chk("t4_next_grant", 32'(bus.grant), 4'b0001);
    chk("t4_err_sticky", 32'(bus.timeout_err), 1);
    bus.req = '0;

    // 5: stop during WAIT
    do_reset();
    bus.req = 4'b0001;
    start_session();
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t5_grant_held", 32'(bus.grant), 4'b0001);
    chk("t5_wait", 32'(bus.state), 2);
    step();
    bus.core_done = 1'b1; bus.core_match = 1'b1;
    step();
    bus.core_done = 1'b0; bus.core_match = 1'b0;
    chk("t5_enable", 32'(bus.enable_count), 1);
    chk("t5_settle", 32'(bus.state), 3);
    step();
    chk("t5_idle", 32'(bus.state), 0);
    chk("t5_busy_off", 32'(bus.busy), 0);
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("t5_start_stop_idle", 32'(bus.state), 0);

    // 6: no-match result, then reset mid-WAIT
    bus.req = 4'b0010;
    start_session();
    step();
    chk("t6_grant", 32'(bus.grant), 4'b0010);
    bus.core_done = 1'b1; bus.core_match = 1'b0;
    step();
    bus.core_done = 1'b0;
    chk("t6_no_enable", 32'(bus.enable_count), 0);
    chk("t6_last_id", 32'(bus.last_id), 1);
    bus.req = 4'b0100;
    step();
    step();
    chk("t6_grant2", 32'(bus.grant), 4'b0100);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req = '0;
    chk("t6_rst_grant", 32'(bus.grant), 0);
    chk("t6_rst_state", 32'(bus.state), 0);
    chk("t6_rst_last_id", 32'(bus.last_id), 3);
    chk("t6_rst_enable", 32'(bus.enable_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
